// File: rtl/alu_operand_stage_pkg.sv
// Shared definitions for the ALU operand preconditioning stage.
//   - ctl bit positions ({zx,nx,zy,ny,f,no}, bit5 = zx)
//   - skid buffer state encoding
//   - 34-bit stored entry layout {ox,oy,f,no}
package alu_operand_stage_pkg;

    localparam int CTL_ZX = 5;
    localparam int CTL_NX = 4;
    localparam int CTL_ZY = 3;
    localparam int CTL_NY = 2;
    localparam int CTL_F  = 1;
    localparam int CTL_NO = 0;

    localparam int OPND_W    = 16;
    localparam int PAYLOAD_W = 2 * OPND_W + 2;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_st_e;

    typedef struct packed {
        logic [OPND_W-1:0] ox;
        logic [OPND_W-1:0] oy;
        logic              f;
        logic              no;
    } opnd_entry_t;

endpackage

// File: rtl/Not16.sv
// Not16: 16-bit bitwise inverter gate.
//   in  - 16-bit operand
//   out - ~in
module Not16 (
    input  logic [15:0] in,
    output logic [15:0] out
);

    assign out = ~in;

endmodule

// File: rtl/skid_buf34.sv
// skid_buf34: 2-entry skid buffer over the 34-bit conditioned operand entry.
//   clk, reset      - clock, synchronous active-high reset
//   in_valid/ready  - upstream handshake; in_ready is registered
//   in_data         - entry to store
//   out_valid/ready - downstream handshake; out_valid is registered
//   out_data        - head entry, always driven from the main register
module skid_buf34
    import alu_operand_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_data
);

    skid_st_e               state;
    logic [PAYLOAD_W-1:0]   main_q;
    logic [PAYLOAD_W-1:0]   skid_q;
    logic                   accept;
    logic                   pop;

    assign accept   = in_valid & in_ready;
    assign pop      = out_valid & out_ready;
    assign out_data = main_q;

    // in_ready/out_valid are written alongside the state they describe,
    // so they are correct in the very cycle the new state is entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        main_q    <= in_data;
                        state     <= ST_ONE;
                        out_valid <= 1'b1;
                    end
                    in_ready <= 1'b1;
                end
                ST_ONE: begin
                    if (accept && pop) begin
                        main_q <= in_data;
                    end else if (accept) begin
                        // Downstream stalled: park the new entry behind main.
                        skid_q   <= in_data;
                        state    <= ST_TWO;
                        in_ready <= 1'b0;
                    end else if (pop) begin
                        state     <= ST_EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                ST_TWO: begin
                    if (pop) begin
                        main_q   <= skid_q;
                        state    <= ST_ONE;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_EMPTY;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: registered operand preconditioning ahead of the ALU.
// Applies zx/zy zeroing then nx/ny inversion to x/y on the input side,
// stores {ox,oy,f,no} in a 2-entry skid buffer and counts accepted transfers.
//   clk, reset          - clock, synchronous active-high reset
//   in_valid/in_ready   - upstream handshake (in_ready registered)
//   x, y, ctl           - raw operands, ctl = {zx,nx,zy,ny,f,no}
//   out_valid/out_ready - downstream handshake
//   ox, oy, f_o, no_o   - conditioned operands and passed-through f/no
//   xfer_cnt            - accepted transfers, wraps mod 2^CNT_W
module alu_operand_stage
    import alu_operand_stage_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       x,
    input  logic [15:0]       y,
    input  logic [5:0]        ctl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       ox,
    output logic [15:0]       oy,
    output logic              f_o,
    output logic              no_o,
    output logic [CNT_W-1:0]  xfer_cnt
);

    logic [15:0]  x1, y1;
    logic [15:0]  x1_n, y1_n;
    opnd_entry_t  cond_entry;
    opnd_entry_t  head_entry;

    // Zero first, then optionally invert the zeroed value.
    assign x1 = ctl[CTL_ZX] ? 16'h0000 : x;
    assign y1 = ctl[CTL_ZY] ? 16'h0000 : y;

    Not16 u_not_x (.in(x1), .out(x1_n));
    Not16 u_not_y (.in(y1), .out(y1_n));

    assign cond_entry.ox = ctl[CTL_NX] ? x1_n : x1;
    assign cond_entry.oy = ctl[CTL_NY] ? y1_n : y1;
    assign cond_entry.f  = ctl[CTL_F];
    assign cond_entry.no = ctl[CTL_NO];

    skid_buf34 u_skid (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (cond_entry),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (head_entry)
    );

    assign ox   = head_entry.ox;
    assign oy   = head_entry.oy;
    assign f_o  = head_entry.f;
    assign no_o = head_entry.no;

    always_ff @(posedge clk) begin
        if (reset) begin
            xfer_cnt <= '0;
        end else if (in_valid && in_ready) begin
            xfer_cnt <= xfer_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [15:0] x, y;
    logic [5:0]  ctl;
    logic        out_ready;

    logic        in_ready,  in_ready4;
    logic        out_valid, out_valid4;
    logic [15:0] ox, oy, ox4, oy4;
    logic        f_o, no_o, f_o4, no_o4;
    logic [15:0] xfer_cnt;
    logic [3:0]  xfer_cnt4;

    int checks = 0;
    int errors = 0;

    // Reference model: a capacity-2 FIFO of expected {ox,oy,f,no} entries.
    logic [33:0] q[$];
    int unsigned acc_total;
    bit          live;   // set once a non-reset edge has passed

    always #5 clk = ~clk;

    alu_operand_stage #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .ctl(ctl), .out_valid(out_valid), .out_ready(out_ready),
        .ox(ox), .oy(oy), .f_o(f_o), .no_o(no_o), .xfer_cnt(xfer_cnt)
    );

    alu_operand_stage #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
        .x(x), .y(y), .ctl(ctl), .out_valid(out_valid4), .out_ready(out_ready),
        .ox(ox4), .oy(oy4), .f_o(f_o4), .no_o(no_o4), .xfer_cnt(xfer_cnt4)
    );

    function automatic logic [33:0] cond(input logic [15:0] a, input logic [15:0] b,
                                         input logic [5:0] c);
        logic [15:0] xa, yb;
        xa = c[5] ? 16'd0 : a;
        if (c[4]) xa = 16'hFFFF - xa;
        yb = c[3] ? 16'd0 : b;
        if (c[2]) yb = 16'hFFFF - yb;
        return {xa, yb, c[1], c[0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_check();
        bit exp_rdy;
        exp_rdy = live && (q.size() < 2);
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
        chk("xfer_cnt", 64'(xfer_cnt), 64'(acc_total % 65536));
        chk("xfer_cnt4", 64'(xfer_cnt4), 64'(acc_total % 16));
        if (q.size() > 0)
            chk("head", 64'({ox, oy, f_o, no_o}), 64'(q[0]));
    endtask

    // Advance one clock with inputs as currently driven, update the model,
    // then compare away from the edge.
    task automatic cycle();
        bit acc, pop;
        acc = !reset && in_valid && live && (q.size() < 2);
        pop = !reset && out_ready && (q.size() > 0);
        @(posedge clk);
        if (reset) begin
            q.delete();
            acc_total = 0;
            live = 0;
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) begin
                q.push_back(cond(x, y, ctl));
                acc_total++;
            end
            live = 1;
        end
        #1;
        model_check();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        in_valid = 1'b0;
        cycle();
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b1; x = 16'hAAAA; y = 16'h5555; ctl = 6'b0;
        out_ready = 1'b0; acc_total = 0; live = 0;
        #1;

        // 1. reset held two cycles with in_valid high
        cycle();
        cycle();
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_ox", 64'(ox), 64'd0);
        chk("rst_oy", 64'(oy), 64'd0);
        chk("rst_cnt", 64'(xfer_cnt), 64'd0);
        reset = 1'b0; in_valid = 1'b0;
        cycle();
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // 2. conditioning
        out_ready = 1'b1;
        in_valid = 1'b1; x = 16'h00FF; y = 16'h1234; ctl = 6'b010100;
        cycle();
        in_valid = 1'b0;
        chk("c1_valid", 64'(out_valid), 64'd1);
        chk("c1_ox", 64'(ox), 64'hFF00);
        chk("c1_oy", 64'(oy), 64'hEDCB);
        cycle();
        in_valid = 1'b1; ctl = 6'b100011;
        cycle();
        in_valid = 1'b0;
        chk("c2_ox", 64'(ox), 64'h0000);
        chk("c2_oy", 64'(oy), 64'h1234);
        chk("c2_f", 64'(f_o), 64'd1);
        chk("c2_no", 64'(no_o), 64'd1);
        cycle();
        in_valid = 1'b1; ctl = 6'b110000;
        cycle();
        in_valid = 1'b0;
        chk("c3_ox", 64'(ox), 64'hFFFF);
        cycle();

        // 3. backpressure
        do_reset();
        out_ready = 1'b0; ctl = 6'b0; y = 16'h0;
        in_valid = 1'b1; x = 16'd1; cycle();
        x = 16'd2; cycle();
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_ox_hold", 64'(ox), 64'd1);
        x = 16'd3; cycle();
        chk("bp_ox_hold2", 64'(ox), 64'd1);
        chk("bp_cnt2", 64'(xfer_cnt), 64'd2);
        out_ready = 1'b1;
        cycle();
        chk("bp_ox2", 64'(ox), 64'd2);
        cycle();
        in_valid = 1'b0;
        chk("bp_ox3", 64'(ox), 64'd3);
        chk("bp_cnt3", 64'(xfer_cnt), 64'd3);
        cycle();
        chk("bp_drained", 64'(out_valid), 64'd0);

        // 4. streaming
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            x = 16'(i);
            cycle();
            chk("stream_ox", 64'(ox), 64'(i));
            chk("stream_rdy", 64'(in_ready), 64'd1);
        end
        in_valid = 1'b0;
        cycle();

        // 5. counter wrap on the CNT_W = 4 instance
        do_reset();
        in_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            x = 16'(i + 100);
            cycle();
        end
        in_valid = 1'b0;
        chk("wrap_cnt4", 64'(xfer_cnt4), 64'd1);
        chk("wrap_cnt16", 64'(xfer_cnt), 64'd17);
        cycle();

        // 6. reset while holding two entries
        out_ready = 1'b0; in_valid = 1'b1;
        x = 16'd5; cycle();
        x = 16'd6; cycle();
        chk("r6_full", 64'(in_ready), 64'd0);
        x = 16'd9; reset = 1'b1; cycle();
        reset = 1'b0; in_valid = 1'b0; cycle();
        chk("r6_empty", 64'(out_valid), 64'd0);
        in_valid = 1'b1; x = 16'd7; out_ready = 1'b1; cycle();
        in_valid = 1'b0;
        chk("r6_first", 64'(ox), 64'd7);
        chk("r6_valid", 64'(out_valid), 64'd1);
        cycle();

        // Randomized traffic against the model, with occasional resets.
        for (int i = 0; i < 400; i++) begin
            reset     = ($urandom_range(0, 59) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            x   = 16'($urandom);
            y   = 16'($urandom);
            ctl = 6'($urandom);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Registered operand-preconditioning stage directly upstream of the ALU's negation/function logic.
- Accepts raw 16-bit x/y operands plus the 6 Hack ALU control bits over a valid/ready handshake.
- Applies zero (zx/zy) then bitwise-negate (nx/ny), and presents the conditioned operands with f/no passed through.
- A 2-entry skid buffer gives full throughput with a registered in_ready.

Parameters:
- CNT_W, 16, width of the accepted-transfer counter xfer_cnt (wraps).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  upstream has a transfer
- in_ready  output  1  stage can accept; registered
- x  input  16  raw operand x
- y  input  16  raw operand y
- ctl  input  6  {zx,nx,zy,ny,f,no}, bit5 = zx
- out_valid  output  1  conditioned operands available
- out_ready  input  1  downstream accepts
- ox  output  16  conditioned x
- oy  output  16  conditioned y
- f_o  output  1  passed-through f
- no_o  output  1  passed-through no
- xfer_cnt  output  CNT_W  count of accepted input transfers, mod 2^CNT_W

Behaviour:
- Conditioning (combinational on the input side, before storage): x1 = zx ? 16'h0000 : x; ox_next = nx ? ~x1 : x1. The same rule applies to y with zy/ny. f and no are stored unchanged.
- accept = in_valid & in_ready; pop = out_valid & out_ready.
- State machine, states EMPTY, ONE, TWO. There are two entry registers, main (drives outputs) and skid.
  - EMPTY: accept -> ONE, main <- conditioned input.
  - ONE, accept & pop -> ONE, main <- input.
  - ONE, accept & !pop -> TWO, skid <- input.
  - ONE, !accept & pop -> EMPTY.
  - ONE, neither -> ONE, hold.
  - TWO: pop -> ONE, main <- skid. Otherwise hold. No accept is possible in TWO (in_ready = 0).
- out_valid = (state != EMPTY). ox/oy/f_o/no_o always come from main.
- in_ready is a registered output: 1 in EMPTY/ONE, 0 in TWO. It is computed as next-state != TWO so it is valid in the same cycle the state is entered.
- Latency: a transfer accepted at edge N appears on outputs with out_valid = 1 after edge N. Throughput is 1 transfer/cycle when out_ready is held high.
- Ordering is strict FIFO. No entry is dropped or duplicated.
- Outputs must stay stable while out_valid & !out_ready.
- xfer_cnt increments by 1 on every accept and wraps from 2^CNT_W-1 to 0.
- Reset (sync, overrides everything in the same cycle):
  - state = EMPTY, out_valid = 0, in_ready = 0 while reset is high, then 1 on the first cycle after reset deasserts.
  - ox = oy = 0, f_o = no_o = 0, xfer_cnt = 0, skid contents = 0.
- Reset mid-operation: buffered entries are discarded with no pop. A concurrent in_valid is ignored.
- The upstream may change x/y/ctl freely while in_valid = 0. While in_valid = 1 & !in_ready, the stage samples nothing.

Decomposition:
- Shared package/header holds:
  - ctl bit-index constants (CTL_ZX = 5, CTL_NX = 4, CTL_ZY = 3, CTL_NY = 2, CTL_F = 1, CTL_NO = 0).
  - State encodings ST_EMPTY = 2'd0, ST_ONE = 2'd1, ST_TWO = 2'd2.
- Negation uses the existing Not16 gate module (two instances, for x1 and y1). Zeroing uses a 16-bit mux.
- One natural sub-module: skid_buf34, the 2-entry skid buffer over a 34-bit payload {ox,oy,f,no}, containing the state machine and in_ready/out_valid logic.
- The top level holds conditioning and xfer_cnt.

Test Plan:
1. Reset held 2 cycles with in_valid = 1 -> out_valid = 0, in_ready = 0 during reset, ox = oy = 0, xfer_cnt = 0. in_ready = 1 on the first post-reset cycle.
2. Conditioning, single transfer with out_ready = 1 (each case -> out_valid = 1 one edge later):
   - x = 16'h00FF, y = 16'h1234, ctl = 6'b010100 -> ox = 16'hFF00, oy = 16'hEDCB.
   - ctl = 6'b100011 -> ox = 0, oy = 16'h1234, f_o = 1, no_o = 1.
   - ctl = 6'b110000 -> ox = 16'hFFFF.
3. Backpressure: out_ready = 0, push x = 1 then x = 2 on consecutive cycles -> state TWO, in_ready = 0, ox holds 1. A third push with x = 3 is not accepted. Raise out_ready -> outputs 1, 2, 3 in order, xfer_cnt = 3.
4. Streaming: in_valid = out_ready = 1 for 20 cycles with x = 0..19 -> one output per cycle, ox sequence 0..19, in_ready never drops.
5. Wrap: CNT_W = 4, 17 accepts -> xfer_cnt = 1.
6. Reset asserted while in TWO with entries 5 and 6 -> after reset out_valid = 0. The next push x = 7 emerges first with ox = 7.
